// File: rtl/icache_dm_if.sv
`default_nettype none
// ============================================================================
// Module      : icache_dm_if
// Description : Fetch-side and backing-memory signal bundle for icache_dm.
// Revision    : 1.0 - initial release
// ============================================================================
interface icache_dm_if;
  logic [31:0] addr;
  logic        flush;
  logic [31:0] instr;
  logic        imem_stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  // Environment side: fetch stage plus backing instruction memory
  modport master (
    output addr, flush, mem_ack, mem_rdata,
    input  instr, imem_stall, mem_req, mem_addr
  );

  modport slave (
    input  addr, flush, mem_ack, mem_rdata,
    output instr, imem_stall, mem_req, mem_addr
  );
endinterface
`default_nettype wire

// File: rtl/icache_dm.sv
`default_nettype none
// ============================================================================
// Module      : icache_dm
// Description : Direct-mapped, one-word-per-line instruction cache with a
//               req/ack refill port. Optional hit/miss counters: ICACHE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_dm #(
  parameter int unsigned LINES     = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  icache_dm_if.slave  bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MISS   = 2'd1,
    ST_REFILL = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [31:0]       data_q [LINES];

  logic [IDX_W-1:0]  idx, cap_idx_q;
  logic [TAG_W-1:0]  tag, cap_tag_q;
  logic              hit, start_miss, fill_we;
  logic              drop_q, drop_d;
  logic              mem_req_q, mem_req_d;
  logic [31:0]       mem_addr_q;

  assign idx = bus.addr[IDX_W+1:2];
  assign tag = bus.addr[31:IDX_W+2];

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    drop_d     = drop_q;
    mem_req_d  = mem_req_q;
    start_miss = 1'b0;
    fill_we    = 1'b0;
    hit        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        hit = valid_q[idx] && (tag_q[idx] == tag);
        if (!hit) begin
          start_miss = 1'b1;
          mem_req_d  = 1'b1;
          state_d    = ST_MISS;
        end
      end
      ST_MISS: begin
        if (bus.flush) drop_d = 1'b1;
        if (bus.mem_ack) begin
          fill_we   = 1'b1;
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
          state_d   = ST_REFILL;
        end
      end
      ST_REFILL: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (bus.flush) valid_d = '0;
    // A flush seen at any point of the miss, including the ack cycle, kills the fill
    if (fill_we && !drop_q && !bus.flush) valid_d[cap_idx_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      drop_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      cap_idx_q  <= '0;
      cap_tag_q  <= '0;
    end else begin
      valid_q   <= valid_d;
      drop_q    <= drop_d;
      mem_req_q <= mem_req_d;
      if (start_miss) begin
        mem_addr_q <= {bus.addr[31:2], 2'b00};
        cap_idx_q  <= idx;
        cap_tag_q  <= tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we && !rst) begin
      data_q[cap_idx_q] <= bus.mem_rdata;
      tag_q[cap_idx_q]  <= cap_tag_q;
    end
  end

  // Fetch latches instr every cycle, so a stalled cycle must present a NOP
  assign bus.imem_stall = !hit;
  assign bus.instr      = hit ? data_q[idx] : NOP_INSTR;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, miss_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (hit)        hit_count_q  <= hit_count_q + 32'd1;
      if (start_miss) miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_dm.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_dm
// Description : Directed bench for icache_dm with a variable-latency memory
//               responder and an expected-word queue. Stats checks: ICACHE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_dm;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr_v = '0;
  logic [31:0] rdata_v = '0;
  logic        flush_v = 1'b0;
  logic        resp_ack = 1'b0;
  logic        stray_ack = 1'b0;
  int          ack_dly = 2;
  int          rsp_cnt = 0;
  bit          rsp_pend = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;
  int          req_count = 0;
  logic [31:0] last_req_addr = '0;
  logic        req_prev = 1'b0;
  logic [31:0] mem_map [logic [31:0]];
  logic [31:0] exp_q [$];

  icache_dm_if bus ();

  assign bus.addr      = addr_v;
  assign bus.flush     = flush_v;
  assign bus.mem_ack   = resp_ack | stray_ack;
  assign bus.mem_rdata = rdata_v;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache_dm #(
    .LINES     (16),
    .NOP_INSTR (NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_map.exists(a)) return mem_map[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  // Backing memory: one-cycle ack, ack_dly cycles after mem_req is first seen
  initial begin
    forever begin
      @(posedge clk); #1;
      resp_ack = 1'b0;
      if (!bus.mem_req) rsp_pend = 1'b0;
      else if (!rsp_pend) begin rsp_pend = 1'b1; rsp_cnt = 1; end
      else rsp_cnt++;
      if (rsp_pend && rsp_cnt >= ack_dly) begin
        resp_ack = 1'b1;
        rdata_v  = mem_word(bus.mem_addr);
        rsp_pend = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.mem_req && !req_prev) begin
      req_count++;
      last_req_addr = bus.mem_addr;
    end
    req_prev = bus.mem_req;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered at posedge+1; returns at posedge+1 after the expected word is seen
  task automatic wait_word(input string tag, input int flush_at, output int stalls);
    bit          done;
    logic [31:0] want;
    done   = 1'b0;
    stalls = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      flush_v = (k == flush_at);
      @(negedge clk);
      if (bus.imem_stall) begin
        chk({tag, " nop"}, bus.instr, NOP);
        stalls++;
        @(posedge clk); #1;
      end else begin
        want = exp_q.pop_front();
        chk(tag, bus.instr, want);
        done = 1'b1;
      end
    end
    chk({tag, " completed"}, {31'b0, done}, 32'd1);
    if (!done) exp_q.delete();
    @(posedge clk); #1;
    flush_v = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] w, input string tag,
                       input int flush_at, output int stalls);
    addr_v = a;
    exp_q.push_back(w);
    wait_word(tag, flush_at, stalls);
  endtask

  initial begin
    int s;
    int r0;
    mem_map[32'h0000_0100] = 32'h00A0_0093;
    mem_map[32'h0000_0200] = 32'h1111_1111;

    rst    = 1'b1;
    addr_v = 32'h0000_0100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("reset mem_addr", bus.mem_addr, 32'd0);
    chk("reset stall", {31'b0, bus.imem_stall}, 32'd1);
    chk("reset instr", bus.instr, NOP);
    @(posedge clk); #1;
    rst = 1'b0;

    ack_dly = 2;
    fetch(32'h100, 32'h00A0_0093, "cold miss", -1, s);
    chk("cold stalls", s, 32'd4);
    chk("cold mem_addr", last_req_addr, 32'h100);
    chk("cold requests", req_count, 32'd1);

    ack_dly = 1;
    for (int i = 1; i < 4; i++) begin
      fetch(32'h100 + 4 * i, mem_word(32'h100 + 4 * i), "preload", -1, s);
      chk("preload stalls", s, 32'd3);
    end
    r0 = req_count;
    for (int i = 0; i < 4; i++) begin
      fetch(32'h100 + 4 * i, mem_word(32'h100 + 4 * i), "stream", -1, s);
      chk("stream stalls", s, 32'd0);
    end
    chk("stream no request", req_count - r0, 32'd0);

    ack_dly = 3;
    r0 = req_count;
    fetch(32'h40, mem_word(32'h40), "conflict a", -1, s);
    chk("conflict a stalls", s, 32'd5);
    fetch(32'h80, mem_word(32'h80), "conflict b", -1, s);
    chk("conflict b stalls", s, 32'd5);
    mem_map[32'h40] = 32'hCAFE_0040;
    fetch(32'h40, 32'hCAFE_0040, "conflict a again", -1, s);
    chk("conflict a again stalls", s, 32'd5);
    chk("conflict requests", req_count - r0, 32'd3);

    ack_dly = 4;
    r0 = req_count;
    fetch(32'h200, 32'h1111_1111, "flush in miss", 2, s);
    chk("flush in miss stalls", s, 32'd12);
    chk("flush in miss requests", req_count - r0, 32'd2);
    chk("flush in miss re-req addr", last_req_addr, 32'h200);

    fetch(32'h200, 32'h1111_1111, "flush on hit", 0, s);
    chk("flush on hit stalls", s, 32'd0);
    fetch(32'h200, 32'h1111_1111, "after idle flush", -1, s);
    chk("after idle flush stalls", s, 32'd6);

    ack_dly = 1;
    fetch(32'h300, mem_word(32'h300), "flush in refill", 2, s);
    chk("flush in refill stalls", s, 32'd6);

    ack_dly = 5;
    addr_v = 32'h500;
    @(negedge clk);
    chk("pre-rst miss stall", {31'b0, bus.imem_stall}, 32'd1);
    @(posedge clk); #1;
    chk("pre-rst mem_req", {31'b0, bus.mem_req}, 32'd1);
    rst    = 1'b1;
    addr_v = 32'h104;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst mid-miss mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst mid-miss mem_addr", bus.mem_addr, 32'd0);
    exp_q.push_back(mem_word(32'h104));
    wait_word("refetch after rst", -1, s);
    chk("refetch after rst stalls", s, 32'd7);
    chk("refetch after rst addr", last_req_addr, 32'h104);

    r0 = req_count;
    rdata_v   = 32'hDEAD_BEEF;
    stray_ack = 1'b1;
    fetch(32'h104, mem_word(32'h104), "stray ack hit", -1, s);
    stray_ack = 1'b0;
    chk("stray ack stalls", s, 32'd0);
    fetch(32'h104, mem_word(32'h104), "after stray ack", -1, s);
    chk("after stray ack stalls", s, 32'd0);
    chk("stray ack requests", req_count - r0, 32'd0);

`ifdef ICACHE_STATS_EN
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("stats reset hit", hit_count, 32'd0);
    chk("stats reset miss", miss_count, 32'd0);
    ack_dly = 1;
    fetch(32'h100, 32'h00A0_0093, "stats cold", -1, s);
    for (int i = 0; i < 4; i++) fetch(32'h100, 32'h00A0_0093, "stats hit", -1, s);
    chk("stats miss_count", miss_count, 32'd1);
    chk("stats hit_count", hit_count, 32'd5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
